// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit common-anode
// seven-segment display. A 32-bit value is shown one hex nibble at a time,
// with an external decoder turning num into the active-low dispcode.
// New values are committed only at frame boundaries, so the display never tears.
module seg_scan_ctrl #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        load,
    output logic        ack,
    input  logic        blank_lz,
    output logic [3:0]  num,
    input  logic [7:0]  dispcode,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    // Nibbles above DIGITS never count towards leading-zero detection.
    localparam logic [31:0]      DMASK    = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                          : 32'((64'd1 << (4 * DIGITS)) - 64'd1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    logic [CNT_W-1:0] prescaler;
    logic [2:0]       idx;
    logic [31:0]      shadow;
    logic [31:0]      pend_val;
    state_t           state;
    state_t           state_nx;
    logic             tick;
    logic             frame_end;
    logic             commit;
    logic             capture;
    logic [31:0]      commit_val;
    logic [31:0]      upper;
    logic             blank;

    assign tick      = (prescaler == DIV_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    // Slot prescaler: counts 0..REFRESH_DIV-1 and wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Digit index advances once per slot and wraps after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 3'd1;
        end
    end

    // Nibble and blanking both derive only from registered state.
    assign num   = shadow[{idx, 2'b00} +: 4];
    assign upper = (shadow & DMASK) >> {idx, 2'b00};
    assign blank = blank_lz && (idx != '0) && (upper == '0);

    // Load FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Load FSM next state: a load coinciding with frame_end bypasses pend_val.
    always_comb begin
        state_nx   = state;
        commit     = 1'b0;
        capture    = 1'b0;
        commit_val = pend_val;
        if (frame_end && (state == PENDING || load)) begin
            commit     = 1'b1;
            commit_val = load ? value : pend_val;
            state_nx   = IDLE;
        end else if (load) begin
            capture    = 1'b1;
            state_nx   = PENDING;
        end
    end

    // Pending/displayed value registers and the commit acknowledge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            shadow   <= '0;
            ack      <= 1'b0;
        end else begin
            ack <= commit;
            if (capture) begin
                pend_val <= value;
            end
            if (commit) begin
                shadow <= commit_val;
            end
        end
    end

    // Registered segment and anode drive, one cycle behind idx/num.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 8'hFF;
            an  <= 8'hFF;
        end else begin
            seg <= blank ? 8'hFF : dispcode;
            an  <= blank ? 8'hFF : ~(8'b1 << idx);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scenarios plus random load/blank traffic, compared
// cycle by cycle against a frame-arithmetic reference model of the display.
module tb_seg_scan_ctrl;

    localparam int R = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] value;
    logic        load;
    logic        ack;
    logic        blank_lz;
    logic [3:0]  num;
    logic [7:0]  dispcode;
    logic [7:0]  seg;
    logic [7:0]  an;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state
    int unsigned m_cyc;
    logic [31:0] m_shown;
    logic [31:0] m_pend;
    bit          m_has;
    logic [7:0]  e_seg;
    logic [7:0]  e_an;
    logic        e_ack;

    always #5 clk = ~clk;

    function automatic logic [7:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 8'hC0; 4'h1: seg7 = 8'hF9; 4'h2: seg7 = 8'hA4; 4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99; 4'h5: seg7 = 8'h92; 4'h6: seg7 = 8'h82; 4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80; 4'h9: seg7 = 8'h90; 4'hA: seg7 = 8'h88; 4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6; 4'hD: seg7 = 8'hA1; 4'hE: seg7 = 8'h86; default: seg7 = 8'h8E;
        endcase
    endfunction

    assign dispcode = seg7(num);

    seg_scan_ctrl #(
        .DIGITS     (D),
        .REFRESH_DIV(R),
        .CNT_W      (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value   (value),
        .load    (load),
        .ack     (ack),
        .blank_lz(blank_lz),
        .num     (num),
        .dispcode(dispcode),
        .seg     (seg),
        .an      (an)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc   = 0;
        m_shown = '0;
        m_pend  = '0;
        m_has   = 1'b0;
        e_seg   = 8'hFF;
        e_an    = 8'hFF;
        e_ack   = 1'b0;
    endtask

    function automatic logic [3:0] cur_num();
        int unsigned d;
        d = (m_cyc / R) % D;
        return 4'(m_shown >> (4 * d));
    endfunction

    // Predict outputs after the coming edge from the current inputs.
    task automatic predict();
        int unsigned d;
        bit          blank;
        bit          fe;
        if (!rst_n) begin
            model_reset();
        end else begin
            d     = (m_cyc / R) % D;
            blank = blank_lz && d != 0 && (m_shown >> (4 * d)) == 0;
            e_seg = blank ? 8'hFF : seg7(cur_num());
            e_an  = blank ? 8'hFF : ~(8'h01 << d);
            fe    = (m_cyc % (R * D)) == (R * D - 1);
            e_ack = 1'b0;
            if (fe && (m_has || load)) begin
                m_shown = load ? value : m_pend;
                m_has   = 1'b0;
                e_ack   = 1'b1;
            end else if (load) begin
                m_pend = value;
                m_has  = 1'b1;
            end
            m_cyc++;
        end
    endtask

    task automatic step(input bit ld, input logic [31:0] val, input bit blz);
        load     = ld;
        value    = val;
        blank_lz = blz;
        predict();
        @(posedge clk);
        #1;
        check("seg", {24'd0, seg}, {24'd0, e_seg});
        check("an",  {24'd0, an},  {24'd0, e_an});
        check("ack", {31'd0, ack}, {31'd0, e_ack});
        check("num", {28'd0, num}, {28'd0, cur_num()});
    endtask

    task automatic run(input int unsigned n, input bit blz);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 32'd0, blz);
    endtask

    // Advance until the next edge lands on frame position p (always < one frame).
    task automatic align(input int unsigned p, input bit blz);
        for (int unsigned i = 0; i < R * D && (m_cyc % (R * D)) != p; i++)
            step(1'b0, 32'd0, blz);
    endtask

    initial begin
        bit          ld;
        bit          blz;
        logic [31:0] v;

        rst_n    = 1'b1;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        run(3, 1'b0);
        rst_n = 1'b1;

        // Idle scan showing 0 on every digit
        run(40, 1'b0);

        // Single-cycle load mid-frame
        align(12, 1'b0);
        step(1'b1, 32'h1234ABCD, 1'b0);
        run(70, 1'b0);

        // Two loads in one frame: only the last survives, one ack
        align(2, 1'b0);
        step(1'b1, 32'h11111111, 1'b0);
        align(10, 1'b0);
        step(1'b1, 32'h00000022, 1'b0);
        run(70, 1'b0);

        // Leading-zero blanking
        step(1'b1, 32'h00000405, 1'b1);
        run(70, 1'b1);
        step(1'b1, 32'h00000000, 1'b1);
        run(70, 1'b1);

        // Load exactly on the frame_end edge
        align(31, 1'b0);
        step(1'b1, 32'h0000BEEF, 1'b0);
        run(40, 1'b0);

        // Asynchronous reset mid-slot with a load pending
        align(5, 1'b0);
        step(1'b1, 32'hCAFE0001, 1'b0);
        run(2, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_seg", {24'd0, seg}, 32'h0000_00FF);
        check("async_an",  {24'd0, an},  32'h0000_00FF);
        check("async_ack", {31'd0, ack}, 32'd0);
        model_reset();
        run(3, 1'b0);
        rst_n = 1'b1;
        run(80, 1'b0);

        // Random traffic: sparse/held loads, leading zeros, blanking toggles
        ld  = 1'b0;
        blz = 1'b0;
        v   = '0;
        for (int unsigned i = 0; i < 900; i++) begin
            if (ld && $urandom_range(0, 2) != 0) begin
                ld = 1'b1;
            end else begin
                ld = ($urandom_range(0, 19) == 0);
                if (ld) v = $urandom & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 8)));
            end
            if ($urandom_range(0, 39) == 0) blz = ~blz;
            step(ld, v, blz);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's common-anode 8-digit seven-segment display. It holds a 32-bit display value and sends one hex nibble at a time on `num` to the external hex-to-segment decoder. It takes the decoder's active-low `dispcode` back, registers it, and drives the shared segment bus and the per-digit anode enables. New values are loaded through a load/ack handshake and take effect only at frame boundaries, so the display never tears.

Parameters:
- DIGITS, 8, number of scanned digits (1..8); nibble i drives digit i, digit 0 is least significant.
- REFRESH_DIV, 100000, clk cycles per digit slot (>=2).
- CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  32  value to display; only nibbles [4*DIGITS-1:0] are used.
- load  in  1  request to latch `value`; single-cycle or held.
- ack  out  1  one-cycle pulse when the pending value is committed to the display.
- blank_lz  in  1  1 = blank leading-zero digits.
- num  out  4  nibble for the current digit, sent to the decoder.
- dispcode  in  8  decoder output for `num`; active-low, bit7 = dp.
- seg  out  8  registered segment bus; active-low.
- an  out  8  registered anode enables; active-low, one-hot-low; bits >= DIGITS are always 1.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - prescaler = 0, idx = 0, shadow = 0, pend_val = 0.
  - Load FSM returns to IDLE.
  - ack = 0, seg = 8'hFF, an = 8'hFF.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (prescaler == REFRESH_DIV-1).
- Digit index:
  - On tick, idx <= (idx == DIGITS-1) ? 0 : idx+1.
  - frame_end = tick && idx == DIGITS-1.
- num = shadow[4*idx+3 : 4*idx]; combinational from registered state, so it has no glitches relative to idx.
- Blanking of digit idx:
  - blank = blank_lz && idx != 0 && shadow[4*DIGITS-1 : 4*idx] == 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Output register, updated every cycle:
  - seg <= blank ? 8'hFF : dispcode.
  - an <= blank ? 8'hFF : ~(8'b1 << idx).
  - seg and an therefore lag idx and num by exactly 1 cycle. There is no overlap between digits, and every digit gets one clean slot of REFRESH_DIV cycles.
- Load FSM, states IDLE and PENDING:
  - IDLE: on load, pend_val <= value and go to PENDING.
  - PENDING: on load, pend_val <= value (last write wins), stay in PENDING.
  - PENDING: on frame_end, shadow <= pend_val, ack <= 1 for one cycle, go to IDLE.
  - load in the same cycle as frame_end while PENDING: the incoming `value` bypasses pend_val and is committed directly; ack pulses; go to IDLE.
  - load in the same cycle as frame_end while IDLE: the value is committed that same frame_end; ack pulses; stay in IDLE.
  - Commit latency from load: 1 to DIGITS*REFRESH_DIV cycles.
- shadow changes only at frame_end. idx 0 after a commit always shows the new value's nibble 0.
- blank_lz is sampled every cycle and may change at any time; it affects the next registered output.
- dispcode must settle combinationally within one clk period of num changing. The block does not check this.

Test Plan (REFRESH_DIV=4, DIGITS=8 unless noted):
- Reset release with no load: an = FF and seg = FF in the reset cycle. After that, an cycles FE, FD, FB, ..., 7F, 4 cycles each. num = 0 throughout; seg = C0 with the decoder model attached.
- load=1 for 1 cycle with value=32'h1234ABCD, blank_lz=0, mid-frame:
  - ack pulses exactly on the frame_end cycle, at the start of the next frame.
  - Next frame: num sequence D,C,B,A,4,3,2,1; seg follows A1,C6,83,88,99,B0,A4,F9, one cycle after each num.
- Two loads in the same frame (32'h11111111, then 32'h00000022):
  - Exactly one ack.
  - 32'h00000022 is displayed; 32'h11111111 never appears.
- blank_lz=1 with value=32'h00000405: digits 0..2 lit (5,0,4); digits 3..7 have an bit = 1 and seg = FF. With value=0, only digit 0 is lit, showing C0.
- load asserted exactly on the frame_end cycle with value=32'h0000BEEF:
  - ack the following cycle.
  - The immediately following frame shows F,E,E,B.
- rst_n pulled low mid-slot with a load PENDING:
  - Outputs go to FF immediately (asynchronously).
  - No ack is ever produced.
  - After release, the display shows 0 until a new load is committed.
